// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: 64-bit byte-lane data-memory requests, load extension, stall and timeout.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [63:0] ALUResult_MEM,
    input  logic [63:0] rs2_data_MEM,
    output logic [63:0] mem_read_data_MEM,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        bus_err,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [63:0] addr_q, wdata_q, rdata_q;
    logic [7:0]  wstrb_q;
    logic [2:0]  f3_q;
    logic        we_q, bus_err_q;

    logic        access, misaligned;
    logic [2:0]  amask, off_a;
    logic [7:0]  strb_base, wstrb_d;
    logic [63:0] addr_d, wdata_d;

    always_comb begin
        amask = 3'b000;
        strb_base = 8'h01;
        case (funct3_MEM[1:0])
            2'd0: begin amask = 3'b000; strb_base = 8'h01; end
            2'd1: begin amask = 3'b001; strb_base = 8'h03; end
            2'd2: begin amask = 3'b011; strb_base = 8'h0F; end
            default: begin amask = 3'b111; strb_base = 8'hFF; end
        endcase
    end

    assign access     = valid_MEM & (MemRead_MEM | MemWrite_MEM);
    assign misaligned = |(ALUResult_MEM[2:0] & amask);
    assign off_a      = ALUResult_MEM[2:0] & ~amask;
    assign addr_d     = {ALUResult_MEM[63:3], off_a};
    assign wstrb_d    = strb_base << off_a;
    assign wdata_d    = rs2_data_MEM << {off_a, 3'b000};

    function automatic logic [63:0] fmt_load(input logic [63:0] rd, input logic [2:0] f3,
                                             input logic [2:0] off);
        logic [63:0] sh;
        sh = rd >> {off, 3'b000};
        case (f3[1:0])
            2'd0:    fmt_load = f3[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
            2'd1:    fmt_load = f3[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    fmt_load = f3[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: fmt_load = sh;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic mis_err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_err_q <= 1'b0;
`endif
        end else begin
            bus_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (access) begin
                    addr_q  <= addr_d;
                    wdata_q <= wdata_d;
                    wstrb_q <= wstrb_d;
                    f3_q    <= funct3_MEM;
                    we_q    <= MemWrite_MEM;
                    rdata_q <= '0;
                    cnt_q   <= '0;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_q   <= DONE;
                        mis_err_q <= 1'b1;
                    end else
`endif
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (dmem_ready) begin
                        rdata_q <= we_q ? 64'b0 : fmt_load(dmem_rdata, f3_q, addr_q[2:0]);
                        state_q <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        // Abandon the request; the bus must tolerate it.
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic busy;
    assign busy = (state_q == BUSY);

    // Reset gates the combinational IDLE stall so every output is 0 while reset is held.
    assign stall_MEM         = reset & (busy | ((state_q == IDLE) & access));
    assign dmem_req          = busy;
    assign dmem_we           = busy & we_q;
    assign dmem_addr         = busy ? {addr_q[63:3], 3'b000} : 64'b0;
    assign dmem_wdata        = busy ? wdata_q : 64'b0;
    assign dmem_wstrb        = busy ? wstrb_q : 8'b0;
    assign mem_read_data_MEM = (state_q == DONE) ? rdata_q : 64'b0;
    assign bus_err           = bus_err_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err      = mis_err_q;
`else
    assign misalign_err      = 1'b0;
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register. It turns the EX/MEM memory controls into byte-lane requests on a single-port 64-bit data-memory bus with a ready handshake. Load data is sign- or zero-extended to 64 bits. The unit stalls the pipeline until each access completes or times out.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without `dmem_ready` before the access aborts with a bus error (1..65535).
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- valid_MEM  in  1  the EX/MEM slot holds a real instruction.
- MemRead_MEM  in  1  load.
- MemWrite_MEM  in  1  store; wins if asserted together with MemRead_MEM.
- funct3_MEM  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 treated as D.
- ALUResult_MEM  in  64  effective byte address.
- rs2_data_MEM  in  64  store data, right-aligned.
- mem_read_data_MEM  out  64  extended load result, valid while `stall_MEM` = 0.
- stall_MEM  out  1  holds PC, IF/ID, ID/EX and EX/MEM, and injects a bubble into MEM/WB.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write request.
- dmem_addr  out  64  doubleword address {addr[63:3],3'b000}.
- dmem_wdata  out  64  lane-shifted store data.
- dmem_wstrb  out  8  byte enables.
- dmem_ready  in  1  request accepted and completed this cycle; `dmem_rdata` valid.
- dmem_rdata  in  64  read doubleword.
- bus_err  out  1  one-cycle pulse on timeout.
- misalign_err  out  1  one-cycle pulse on a misaligned access (see Configuration).

## Operation
- Access = valid_MEM & (MemRead_MEM | MemWrite_MEM).
- Size in bytes is 1/2/4/8 from funct3[1:0]. Offset = addr[2:0].
- wstrb = ((1<<size)-1) << offset. wdata = rs2_data_MEM << (8*offset).
- Load result = (dmem_rdata >> 8*offset), truncated to the size, then sign-extended for funct3[2]=0 or zero-extended for funct3[2]=1. 111 uses the full doubleword.
- FSM states:
  - IDLE: on access, `stall_MEM`=1, latch addr/we/wdata/wstrb/funct3 → BUSY. Otherwise `stall_MEM`=0 and `mem_read_data_MEM`=0.
  - BUSY: `dmem_req`=1 with the latched fields, `stall_MEM`=1, timeout counter increments.
    - On `dmem_ready`: store formatted read data (0 for stores) in rdata_q → DONE.
    - If the counter reaches TIMEOUT_CYCLES first: drop `dmem_req`, rdata_q=0, `bus_err` pulses in DONE → DONE.
  - DONE: `stall_MEM`=0, `mem_read_data_MEM`=rdata_q, and MEM/WB captures at the end of this cycle → IDLE.
- The instruction seen in IDLE after DONE is always the next one, because EX/MEM advances at the DONE edge.
- The timeout counter clears on entry to BUSY.

## Timing
- Reset: while `reset`=0, every output is 0 (including `stall_MEM` and `dmem_req`), state = IDLE, counter and latches = 0.
- Reset asserted mid-access drops `dmem_req` immediately (asynchronously). The bus must tolerate an abandoned request.
- Latency with zero-wait `dmem_ready`: 3 cycles per access (IDLE, BUSY, DONE), with `stall_MEM` high for 2 cycles. Each wait cycle adds 1.
- Non-memory instructions take 0 extra cycles.
- `dmem_req` stays high with stable fields until `dmem_ready` or timeout. Requests are never withdrawn early except on reset.
- `dmem_ready` sampled outside BUSY is ignored.
- Back-to-back accesses: the second starts in the IDLE cycle right after DONE. No idle gap is added beyond that.

## Configuration
- MISALIGN_TRAP_EN defined: an access whose offset is not a multiple of the size issues no bus request. The FSM goes IDLE→DONE: `stall_MEM` is high for 1 cycle, `misalign_err` pulses in DONE, and `mem_read_data_MEM`=0.
- MISALIGN_TRAP_EN undefined: the low address bits are cleared to size alignment (addr & ~(size-1)) and the access proceeds normally. `misalign_err` is tied to 0.

## Test plan
- LD from 0x1000 with dmem_rdata=0x8877665544332211 and ready in the first BUSY cycle → `stall_MEM` high 2 cycles; `mem_read_data_MEM`=0x8877665544332211 in DONE.
- LB from 0x1003 (rdata as above) → 0x0000000000000044. LH from 0x1006 → 0xFFFFFFFFFFFF8877. LHU from 0x1006 → 0x8877. LWU from 0x1004 → 0x88776655.
- SH of rs2=0xABCD to 0x2002 → dmem_we=1, dmem_addr=0x2000, wstrb=0x0C, wdata=0x00000000ABCD0000. Three wait cycles → `stall_MEM` high 5 cycles.
- With TIMEOUT_CYCLES=4 and `dmem_ready` never asserted → `dmem_req` high 4 cycles, then `bus_err` 1-cycle pulse, `mem_read_data_MEM`=0, and the pipeline resumes.
- Pull `reset` low during BUSY of an LW → `dmem_req` and `stall_MEM` fall in the same cycle. After release, state is IDLE and the next LW completes normally.
- LW at 0x1002:
  - With MISALIGN_TRAP_EN: no `dmem_req`, `misalign_err` pulse, 1 stall cycle.
  - Without: access at 0x1000 with wstrb/extraction for offset 0, and `misalign_err` stays 0.
